// File: rtl/mc_ise_pkg.sv
// mc_ise_pkg: GF(2^8) helpers, MixColumns coefficients and FSM state type for mc_ise
package mc_ise_pkg;

  localparam logic [7:0] GF_POLY = 8'h1B;
  localparam logic [7:0] FWD_C [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
  localparam logic [7:0] INV_C [4] = '{8'h0E, 8'h0B, 8'h0D, 8'h09};

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_CALC   = 2'd1,
    ST_UNLOAD = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
  endfunction

  // Every coefficient fits in 4 bits, so four doubling steps cover the product.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p = x;
    for (int k = 0; k < 4; k++) begin
      acc = c[k] ? acc ^ p : acc;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/mc_col_byte.sv
// mc_col_byte: one output row of (Inv)MixColumns for a single state column
module mc_col_byte
  import mc_ise_pkg::*;
(
  input  logic [7:0] s0,
  input  logic [7:0] s1,
  input  logic [7:0] s2,
  input  logic [7:0] s3,
  input  logic [1:0] row,
  input  logic       mode,
  output logic [7:0] y
);

  logic [7:0] w_s [4];

  assign w_s = '{s0, s1, s2, s3};

  // r_row = XOR over j of c[(j-row) mod 4] * s_j; the 2-bit subtraction wraps mod 4
  always_comb begin
    logic [1:0] k;
    y = '0;
    for (int j = 0; j < 4; j++) begin
      k = 2'(j) - row;
      y = y ^ gmul(w_s[j], mode ? INV_C[k] : FWD_C[k]);
    end
  end

endmodule

// File: rtl/mc_ise.sv
// mc_ise: iterative MixColumns/InvMixColumns ISE with load, calc and unload phases
module mc_ise
  import mc_ise_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [8*LANES-1:0]   a,
  input  logic [8*LANES-1:0]   b,
  input  logic [7:0]           sr,
  output logic [7:0]           sr_out,
  output logic [8*LANES-1:0]   result,
  output logic                 wait_req
);

  localparam int LOADS   = 4 / (2 * LANES);
  localparam int UNLOADS = 4 / LANES;

  if (LANES != 1 && LANES != 2) begin : g_bad_lanes
    $error("mc_ise: LANES must be 1 or 2");
  end

  state_t     r_state;
  logic       r_ld_cnt;
  logic [1:0] r_un_cnt;
  logic [1:0] r_calc_cnt;
  logic       r_mode_q;
  logic [7:0] r_s [4];
  logic [7:0] r_r [4];
  logic [7:0] w_y;
  logic       w_last_ld;
  logic       w_last_un;

  assign w_last_ld = int'(r_ld_cnt) == LOADS - 1;
  assign w_last_un = int'(r_un_cnt) == UNLOADS - 1;
  assign sr_out    = sr;
  // Gated by rst so the stall is dropped while the block is held in reset.
  assign wait_req  = rst & ((r_state == ST_CALC) | (r_state == ST_LOAD & start & w_last_ld));

  mc_col_byte u_col (
    .s0   (r_s[0]),
    .s1   (r_s[1]),
    .s2   (r_s[2]),
    .s3   (r_s[3]),
    .row  (r_calc_cnt),
    .mode (r_mode_q),
    .y    (w_y)
  );

  // Present the current unload group, highest result bytes first.
  always_comb begin
    result = '0;
    for (int l = 0; l < LANES; l++)
      result[8*l +: 8] = (r_state == ST_UNLOAD) ? r_r[2'(4 - LANES * (int'(r_un_cnt) + 1) + l)] : 8'h00;
  end

  // Phase sequencing: capture operands, compute one row per cycle, hand out results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_LOAD;
      r_ld_cnt   <= 1'b0;
      r_un_cnt   <= '0;
      r_calc_cnt <= '0;
      r_mode_q   <= 1'b0;
      r_s        <= '{default: '0};
      r_r        <= '{default: '0};
    end else begin
      unique case (r_state)
        ST_LOAD: if (start) begin
          for (int l = 0; l < LANES; l++) begin
            r_s[2'(int'(r_ld_cnt) * 2 * LANES + l)]         <= a[8*l +: 8];
            r_s[2'(int'(r_ld_cnt) * 2 * LANES + LANES + l)] <= b[8*l +: 8];
          end
          if (w_last_ld) begin
            r_mode_q   <= mode;
            r_ld_cnt   <= 1'b0;
            r_calc_cnt <= '0;
            r_state    <= ST_CALC;
          end else begin
            r_ld_cnt <= r_ld_cnt + 1'b1;
          end
        end
        ST_CALC: begin
          r_r[r_calc_cnt] <= w_y;
          r_calc_cnt      <= r_calc_cnt + 2'd1;
          if (r_calc_cnt == 2'd3) begin
            r_un_cnt <= '0;
            r_state  <= ST_UNLOAD;
          end
        end
        ST_UNLOAD: if (start) begin
          r_un_cnt <= w_last_un ? 2'd0 : r_un_cnt + 2'd1;
          r_state  <= w_last_un ? ST_LOAD : ST_UNLOAD;
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

endmodule
